// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Time-multiplexed driver for a common-cathode seven-segment display.
// Digits are scanned one at a time. Each digit is preceded by a dark blanking
// gap so the previous pattern does not ghost onto the next digit. New patterns
// arrive through a valid/ready handshake. They are held in a pending register
// and move into the displayed (active) register only at a frame boundary, so a
// frame is never torn.
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_seg_in       per-digit segment patterns, digit k at [7k+6:7k], active-high
//   i_blank_in     per-digit blank mask, 1 = digit shows nothing
//   i_load_valid   i_seg_in / i_blank_in valid this cycle
//   o_load_ready   a load can be accepted (pending register empty)
//   o_led_out      segment drive for the enabled digit, active-high
//   o_digit_en     digit enables, one-hot or zero, active-high
//   o_frame_done   one-cycle pulse in the first BLANK cycle of digit 0
//
// state  | meaning
// -------+-----------------------------------------------------------
// BLANK  | all digits dark for BLANK_COUNT cycles before digit r_idx
// SHOW   | digit r_idx lit with its active pattern for SCAN_COUNT cycles

module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_COUNT  = 16_000,
    parameter int BLANK_COUNT = 160
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7*NUM_DIGITS-1:0] i_seg_in,
    input  logic [NUM_DIGITS-1:0]   i_blank_in,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    output logic [6:0]              o_led_out,
    output logic [NUM_DIGITS-1:0]   o_digit_en,
    output logic                    o_frame_done
);

    localparam int MAX_CNT = (SCAN_COUNT > BLANK_COUNT) ? SCAN_COUNT : BLANK_COUNT;
    // A one-cycle dwell would give a zero-width counter; keep at least one bit.
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SCAN_TC  = CNT_W'(SCAN_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_wrap;

    logic [7*NUM_DIGITS-1:0] r_act_seg;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [7*NUM_DIGITS-1:0] r_pend_seg;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pend_full;
    logic                    r_frame_done;
    logic                    w_accept;
    logic [6:0]              w_digit_seg;

    // Scan sequencer: dwell counter counts up from 0 to the terminal count of
    // the current state, then restarts for the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_wrap      = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_TC) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == SCAN_TC) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_accept = i_load_valid && !r_pend_full;

    // Active only changes on the wrap edge. A pending pattern wins; with
    // pending empty, a load accepted on that very edge bypasses straight in.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_act_seg    <= '0;
            r_act_blank  <= '0;
            r_pend_seg   <= '0;
            r_pend_blank <= '0;
            r_pend_full  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_wrap) begin
                if (r_pend_full) begin
                    r_act_seg   <= r_pend_seg;
                    r_act_blank <= r_pend_blank;
                    r_pend_full <= 1'b0;
                end else if (w_accept) begin
                    r_act_seg   <= i_seg_in;
                    r_act_blank <= i_blank_in;
                end
            end else if (w_accept) begin
                r_pend_seg   <= i_seg_in;
                r_pend_blank <= i_blank_in;
                r_pend_full  <= 1'b1;
            end
        end
    end

    assign w_digit_seg = r_act_seg[7*r_idx +: 7];

    always_comb begin
        o_digit_en = '0;
        o_led_out  = '0;
        if (r_state == ST_SHOW) begin
            o_digit_en = NUM_DIGITS'(1) << r_idx;
            if (!r_act_blank[r_idx]) begin
                o_led_out = w_digit_seg;
            end
        end
    end

    assign o_load_ready = !r_pend_full;
    assign o_frame_done = r_frame_done;

endmodule
